// File: rtl/adc_sdo_capture.sv
// Serial ADC front end: issues CONVST, waits out the conversion, then clocks NUM_BITS
// bits in on ADC_SCK (MSB first) and publishes the previous frame's result with its channel.
module adc_sdo_capture #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int NUM_BITS    = 12
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                START,
  input  logic [3:0]          CH_ACTUAL,
  input  logic                ADC_SDO,
  output logic                ADC_CONVST,
  output logic                ADC_SCK,
  output logic                flag,
  output logic [NUM_BITS-1:0] DATA,
  output logic [3:0]          DATA_CH,
  output logic                DATA_VALID,
  output logic                BUSY,
  output logic [2:0]          state_dbg
);

  localparam int CNT_W = $clog2((CONV_CYCLES > 2) ? CONV_CYCLES : 2);
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(NUM_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONVST = 3'd1,
    CONV   = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PH_W-1:0]     phase;
  logic [BIT_W-1:0]    bit_cnt;
  logic [NUM_BITS-1:0] sreg;
  logic [3:0]          ch_cur;
  logic [3:0]          ch_prev;
  logic                primed;

  assign state_dbg = state;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      ch_cur     <= '0;
      ch_prev    <= '0;
      primed     <= 1'b0;
      ADC_CONVST <= 1'b0;
      ADC_SCK    <= 1'b0;
      flag       <= 1'b0;
      DATA       <= '0;
      DATA_CH    <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state      <= CONVST;
            cnt        <= '0;
            ADC_CONVST <= 1'b1;
            flag       <= 1'b1;
            BUSY       <= 1'b1;
            ch_cur     <= CH_ACTUAL;
            ch_prev    <= ch_cur;
          end
        end
        CONVST: begin
          if (cnt == CNT_W'(1)) begin
            state      <= CONV;
            cnt        <= '0;
            ADC_CONVST <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONV: begin
          if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
            state   <= SHIFT;
            cnt     <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            ADC_SCK <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // phase 0 is the first high cycle of each SCK period, i.e. the rising edge
          if (phase == '0) sreg <= {sreg[NUM_BITS-2:0], ADC_SDO};
          if (phase == PH_W'(2 * CLK_DIV - 1)) begin
            phase <= '0;
            if (bit_cnt == BIT_W'(NUM_BITS - 1)) begin
              state   <= DONE;
              bit_cnt <= '0;
              ADC_SCK <= 1'b0;
              flag    <= 1'b0;
              primed  <= 1'b1;
              // the very first frame after reset only primes the ADC's channel mux
              if (primed) begin
                DATA       <= sreg;
                DATA_CH    <= ch_prev;
                DATA_VALID <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ADC_SCK <= 1'b1;
            end
          end else begin
            phase   <= phase + 1'b1;
            ADC_SCK <= (phase < PH_W'(CLK_DIV - 1));
          end
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
